// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx_arbiter slice: FSM state encoding,
// default requester count and the index width used for grant/pointer values.
package uart_arb_pkg;

  localparam int NREQ_DEFAULT = 4;

  // Wide enough to index up to eight requesters.
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: starting one above i_ptr and wrapping,
// returns the first active request as a one-hot grant plus its index.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int k;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    k       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      k = (int'(i_ptr) + off) % NREQ;
      if (!o_valid && i_req[k]) begin
        o_valid    = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte requesters.
// Define UART_ARB_LOCK_EN to keep the grant until a requester's last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_ready,
  output logic              o_busy
);

`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // Requester 0 has first priority after reset.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NREQ - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_idx;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_ack;
  logic              r_last;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;

  logic [NREQ-1:0]   w_pick_grant;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic [7:0]        w_byte;
  logic              w_last;
  logic              w_owner_req;
  logic              w_keep_lock;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) w_byte = i_data[8*k +: 8];
    end
  end

  assign w_last      = |(i_last & r_grant);
  assign w_owner_req = |(i_req & r_grant);
  assign w_keep_lock = LOCK_EN && !r_last && w_owner_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= PTR_RST;
      r_idx      <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every branch reads pre-edge state.
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_grant;
            r_idx   <= w_pick_idx;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_tx_ready) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_ack      <= r_grant;
            r_last     <= w_last;
            r_state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!i_tx_ready) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_tx_ready) begin
            r_ptr <= r_idx;
            // A locked owner with more packet bytes skips rearbitration.
            if (w_keep_lock) begin
              r_state <= ST_LOAD;
            end else begin
              r_grant <= '0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack      = r_ack;
  assign o_grant    = r_grant;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a uart_tx model
// react to the DUT; expected (requester, byte) order is queued per scenario.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } byte_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   i_req;
  logic [8*NREQ-1:0] i_data;
  logic [NREQ-1:0]   i_last;
  logic [NREQ-1:0]   o_ack;
  logic [NREQ-1:0]   o_grant;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              i_tx_ready;
  logic              o_busy;

  uart_tx_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ack      (o_ack),
    .o_grant    (o_grant),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  byte_t byte_q [NREQ][$];
  exp_t  exp_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    n_starts = 0;
  int    n_acks = 0;
  int    ack_cnt [NREQ];
  int    last_start_cyc = 0;
  int    uart_cnt = 0;
  logic  uart_hold = 1'b0;

  task automatic drive_reqs();
    for (int k = 0; k < NREQ; k++) begin
      if (byte_q[k].size() > 0) begin
        i_req[k]          = 1'b1;
        i_data[8*k +: 8]  = byte_q[k][0].data;
        i_last[k]         = byte_q[k][0].last;
      end else begin
        i_req[k]          = 1'b0;
        i_data[8*k +: 8]  = 8'h00;
        i_last[k]         = 1'b0;
      end
    end
  endtask

  task automatic load(input int k, input logic [7:0] data, input logic last);
    byte_q[k].push_back('{last: last, data: data});
    drive_reqs();
  endtask

  task automatic expect_byte(input int k, input logic [7:0] data);
    exp_q.push_back('{idx: 3'(k), data: data});
  endtask

  // One clock: sample outputs on the falling edge, then update the models.
  task automatic step();
    exp_t            e;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    cyc++;
    n_tests++;
    if (o_ack !== '0 && o_tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_without_start cyc=%0d ack=%b start=%b", cyc, o_ack, o_tx_start);
    end
    if (o_tx_start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start cyc=%0d data=%h grant=%b", cyc, o_tx_data, o_grant);
      end else begin
        e  = exp_q.pop_front();
        oh = NREQ'(32'd1 << e.idx);
        if (o_tx_data !== e.data) begin
          n_fail++;
          $display("FAIL tx_data cyc=%0d got=%h exp=%h", cyc, o_tx_data, e.data);
        end
        n_tests++;
        if (o_grant !== oh) begin
          n_fail++;
          $display("FAIL tx_owner cyc=%0d grant=%b exp=%b", cyc, o_grant, oh);
        end
        n_tests++;
        if (o_ack !== oh) begin
          n_fail++;
          $display("FAIL ack_bit cyc=%0d ack=%b exp=%b", cyc, o_ack, oh);
        end
      end
      uart_cnt = 4;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (o_ack[k] === 1'b1) begin
        n_acks++;
        ack_cnt[k]++;
        if (byte_q[k].size() > 0) void'(byte_q[k].pop_front());
      end
    end
    i_tx_ready = !uart_hold && (uart_cnt == 0);
    drive_reqs();
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0);
    for (int k = 0; k < NREQ; k++) if (byte_q[k].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((pending() || o_busy !== 1'b0 || i_tx_ready !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout left=%0d busy=%b", name, exp_q.size(), o_busy);
    end
  endtask

  task automatic wait_start(input int budget, input string name);
    int s0 = n_starts;
    int n  = 0;
    while (n_starts == s0 && n < budget) begin
      step();
      n++;
    end
    n_tests++;
    if (n_starts == s0) begin
      n_fail++;
      $display("FAIL %s_no_start after %0d cycles", name, n);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_tests++;
    if ({o_grant, o_ack, o_tx_start, o_tx_data, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL %s grant=%b ack=%b start=%b data=%h busy=%b exp all zero",
               name, o_grant, o_ack, o_tx_start, o_tx_data, o_busy);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < NREQ; k++) byte_q[k].delete();
    exp_q.delete();
    uart_cnt   = 0;
    uart_hold  = 1'b0;
    i_tx_ready = 1'b1;
    drive_reqs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    check_outputs_zero("reset_async");
    step();
    step();
    check_outputs_zero("reset_held");
    rst = 1'b0;
    step();
    check_outputs_zero("reset_idle");
  endtask

  task automatic test_single();
    int t0;
    int a0 = ack_cnt[2];
    expect_byte(2, 8'hA5);
    load(2, 8'hA5, 1'b1);
    t0 = cyc;
    wait_start(10, "single");
    n_tests++;
    if (last_start_cyc - t0 != 2) begin
      n_fail++;
      $display("FAIL single_latency got=%0d exp=2", last_start_cyc - t0);
    end
    wait_drain(50, "single");
    n_tests++;
    if (ack_cnt[2] - a0 != 1) begin
      n_fail++;
      $display("FAIL single_ack_count got=%0d exp=1", ack_cnt[2] - a0);
    end
    n_tests++;
    if (o_tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL tx_data_hold got=%h exp=a5", o_tx_data);
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int k = 0; k < NREQ; k++) expect_byte(k, 8'h10 + 8'(k));
    for (int k = 0; k < NREQ; k++) load(k, 8'h10 + 8'(k), 1'b1);
    wait_drain(200, "rr_order");
  endtask

  task automatic test_ready_low();
    int s0 = n_starts;
    int a0 = n_acks;
    uart_hold  = 1'b1;
    i_tx_ready = 1'b0;
    expect_byte(1, 8'h3C);
    load(1, 8'h3C, 1'b1);
    repeat (20) step();
    n_tests++;
    if (n_starts != s0 || n_acks != a0) begin
      n_fail++;
      $display("FAIL ready_low_pulses starts=%0d acks=%0d exp=0,0", n_starts - s0, n_acks - a0);
    end
    n_tests++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_low_busy got=%b exp=1", o_busy);
    end
    uart_hold  = 1'b0;
    i_tx_ready = 1'b1;
    wait_drain(50, "ready_low");
    n_tests++;
    if (n_starts - s0 != 1 || n_acks - a0 != 1) begin
      n_fail++;
      $display("FAIL ready_low_once starts=%0d acks=%0d exp=1,1", n_starts - s0, n_acks - a0);
    end
  endtask

  task automatic test_lock();
    do_reset();
`ifdef UART_ARB_LOCK_EN
    expect_byte(1, 8'h11);
    expect_byte(1, 8'h12);
    expect_byte(1, 8'h13);
    expect_byte(0, 8'h0A);
`else
    expect_byte(1, 8'h11);
    expect_byte(0, 8'h0A);
    expect_byte(1, 8'h12);
    expect_byte(1, 8'h13);
`endif
    load(1, 8'h11, 1'b0);
    load(1, 8'h12, 1'b0);
    load(1, 8'h13, 1'b1);
    wait_start(10, "lock");
    load(0, 8'h0A, 1'b1);
    wait_drain(200, "lock");
  endtask

  task automatic test_reset_mid();
    int a0;
    int s0;
    expect_byte(2, 8'h77);
    load(2, 8'h77, 1'b1);
    wait_start(10, "reset_mid");
    step();
    step();
    a0 = n_acks;
    s0 = n_starts;
    #2 rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_async");
    step();
    check_outputs_zero("reset_mid_next");
    rst = 1'b0;
    repeat (10) step();
    n_tests++;
    if (n_acks != a0 || n_starts != s0) begin
      n_fail++;
      $display("FAIL reset_mid_extra acks=%0d starts=%0d exp=0,0", n_acks - a0, n_starts - s0);
    end
    expect_byte(0, 8'h5A);
    expect_byte(3, 8'h33);
    load(3, 8'h33, 1'b1);
    load(0, 8'h5A, 1'b1);
    wait_drain(200, "reset_mid");
  endtask

  initial begin
    rst        = 1'b1;
    i_req      = '0;
    i_data     = '0;
    i_last     = '0;
    i_tx_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) ack_cnt[k] = 0;
    test_reset();
    test_single();
    test_rr_order();
    test_ready_low();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
